calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Top-level sequencer for the 8-bit two-function calculator.
- Consumes keypad command strobes and the signed operand produced by the input unit.
- Collects operand A, the operator and operand B, then runs one add/subtract on the shared ALU through a start/done handshake.
- Holds the result for the display and supports chained operations.
- Guards the ALU handshake with a timeout watchdog.

## Interface
- ALU_TIMEOUT, 15: number of WAIT cycles allowed without alu_done before ERR (legal range 2–255).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_code valid.
- key_code  in  4  0xA = ADD, 0xB = SUB, 0xC = CLEAR, 0xE = ENTER, 0xF = EQUALS; all other codes are ignored.
- operand  in  8  two's-complement value from the input unit; sampled only on ENTER.
- alu_start  out  1  one-cycle request pulse to the ALU.
- alu_a, alu_b  out  8  ALU operands; stable from EXEC through WAIT.
- alu_sub  out  1  0 = A+B, 1 = A−B.
- alu_done  in  1  ALU completion strobe.
- alu_result  in  8  ALU result; valid with alu_done.
- alu_ovf  in  1  ALU overflow; valid with alu_done.
- result  out  8  last captured result.
- overflow  out  1  overflow flag of the last result.
- busy  out  1  high in EXEC or WAIT.
- error  out  1  high in ERR.
- state  out  3  current state encoding, for debug LEDs.

## Operation
- States and encodings: IDLE = 0, GOT_A = 1, GOT_OP = 2, GOT_B = 3, EXEC = 4, WAIT = 5, SHOW = 6, ERR = 7.
- IDLE: ENTER → A←operand, go to GOT_A. All other keys ignored.
- GOT_A: ADD/SUB → latch operator, go to GOT_OP. ENTER → re-latch A.
- GOT_OP: ENTER → B←operand, go to GOT_B. ADD/SUB → replace operator.
- GOT_B: EQUALS → EXEC. ENTER → re-latch B. ADD/SUB ignored.
- EXEC: lasts exactly one cycle. alu_start=1, watchdog cleared, then → WAIT.
- WAIT: alu_done → result←alu_result, overflow←alu_ovf, go to SHOW. If no done arrives within ALU_TIMEOUT cycles → ERR.
- SHOW (result chaining):
  - ADD/SUB → A←result, latch operator, go to GOT_OP.
  - ENTER → A←operand, go to GOT_A.
  - EQUALS → repeat the operation with A←result and the same B/operator, via EXEC.
- ERR: only CLEAR leaves this state.
- CLEAR in any state (including EXEC/WAIT):
  - Next state IDLE.
  - A, B, operator, result, overflow and error cleared.
  - The in-flight operation is abandoned; a late alu_done is ignored outside WAIT.
- Keys other than CLEAR are ignored in EXEC, WAIT and ERR.
- Arithmetic is performed by the external ALU only. result is the 8-bit two's-complement value as returned, with no saturation.

## Timing
- Reset (reset=0 at a clock edge): state=IDLE; alu_start, alu_a, alu_b, alu_sub, result, overflow, busy and error all 0.
- Key strobe sampled at edge N → state change visible after edge N. alu_start is high for exactly the cycle after the EQUALS edge.
- alu_done is honoured only in WAIT. A done coincident with alu_start (the EXEC cycle) is ignored.
- Minimum latency EQUALS → result valid = 3 edges, when alu_done arrives in the first WAIT cycle.
- Watchdog:
  - Counts WAIT cycles with alu_done low.
  - On the ALU_TIMEOUT-th such cycle → ERR on the next edge.
  - alu_done in that same final cycle wins: go to SHOW.
- CLEAR and reset in the same cycle: reset dominates (identical outcome).
- CLEAR and alu_done in the same WAIT cycle: CLEAR wins; result stays 0.
- Outputs are registered. state, busy and error change only at edges.

## Structure
- Shared package calc_pkg holds:
  - the state encoding typedef;
  - key-code constants KEY_ADD, KEY_SUB, KEY_CLR, KEY_ENT, KEY_EQ;
  - the ALU_TIMEOUT default.
- One sub-module, calc_watchdog: an 8-bit counter with clear/enable inputs and an expired output, parameterised by ALU_TIMEOUT.
- FSM, operand registers and result registers live in calc_sequencer.

## Test plan
- Basic add: ENTER(operand=0x05), ADD, ENTER(0x03), EQUALS, ALU returns 0x08 one cycle after start → result=0x08, overflow=0, state=SHOW, alu_start high for one cycle.
- Subtract with chaining:
  - 0x0A SUB 0x0F = 0xFB.
  - Then ADD, ENTER(0x05), EQUALS → alu_a=0xFB, alu_sub=0, result=0x00.
- Overflow passthrough: 0x7F ADD 0x01, ALU returns 0x80 with ovf=1 → result=0x80, overflow=1.
- Timeout: EQUALS with alu_done held low → error=1 and state=7 after exactly ALU_TIMEOUT WAIT cycles. Further keys are ignored; CLEAR → IDLE with all outputs 0.
- Abort: CLEAR during WAIT, then alu_done pulses → state stays IDLE, result stays 0x00.
- Reset: reset=0 mid-WAIT → next edge all outputs 0 and state IDLE. Operator keys in GOT_B are ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the 8-bit two-function calculator:
// sequencer state encoding, keypad codes and the default ALU watchdog limit.
package calc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GOT_A  = 3'd1,
        S_GOT_OP = 3'd2,
        S_GOT_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WAIT   = 3'd5,
        S_SHOW   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_ENT = 4'hE;
    localparam logic [3:0] KEY_EQ  = 4'hF;

    localparam int unsigned ALU_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/calc_if.sv
// ALU request/response bundle between the calculator sequencer and the ALU.
// master: drives alu_start/alu_a/alu_b/alu_sub, receives alu_done/alu_result/alu_ovf.
// slave : the ALU side of the same handshake.
interface calc_if;

    logic       alu_start;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sub;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_ovf;

    modport master (
        output alu_start, alu_a, alu_b, alu_sub,
        input  alu_done, alu_result, alu_ovf
    );

    modport slave (
        input  alu_start, alu_a, alu_b, alu_sub,
        output alu_done, alu_result, alu_ovf
    );

endinterface

// File: rtl/calc_watchdog.sv
// Timeout counter guarding the ALU handshake.
// Ports: clk, reset (sync, active-low), clear (zero the count), enable (count
// this cycle), expired (this enabled cycle is the ALU_TIMEOUT-th one).
module calc_watchdog #(
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(ALU_TIMEOUT - 1);

    logic [7:0] count;

    // Saturates so a stuck enable can never wrap back below LAST.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // count holds the number of earlier idle cycles, so the current one
    // is the last allowed when count has reached ALU_TIMEOUT-1.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects A, operator and B from keypad strobes, runs
// one add/subtract on the external ALU via start/done, holds and chains results.
// Ports: clk, reset (sync, active-low), key_valid/key_code/operand (keypad),
// alu (ALU handshake, master side), result/overflow (display), busy, error, state.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = ALU_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [7:0] operand,
    calc_if.master     alu,
    output logic [7:0] result,
    output logic       overflow,
    output logic       busy,
    output logic       error,
    output logic [2:0] state
);

    state_t     st, nxt;
    logic [7:0] a_q, a_n;
    logic [7:0] b_q, b_n;
    logic [7:0] res_q, res_n;
    logic       sub_q, sub_n;
    logic       ovf_q, ovf_n;
    logic       start_q, busy_q, err_q;

    logic k_add, k_sub, k_clr, k_ent, k_eq, k_op;
    logic wd_clear, wd_enable, wd_expired;

    always_comb begin
        k_add = 1'b0;
        k_sub = 1'b0;
        k_clr = 1'b0;
        k_ent = 1'b0;
        k_eq  = 1'b0;
        if (key_valid) begin
            unique case (key_code)
                KEY_ADD: k_add = 1'b1;
                KEY_SUB: k_sub = 1'b1;
                KEY_CLR: k_clr = 1'b1;
                KEY_ENT: k_ent = 1'b1;
                KEY_EQ:  k_eq  = 1'b1;
                default: ;
            endcase
        end
    end

    assign k_op = k_add | k_sub;

    // Count only idle WAIT cycles; a done in the final cycle still wins.
    assign wd_clear  = (st == S_EXEC) || k_clr;
    assign wd_enable = (st == S_WAIT) && !alu.alu_done;

    calc_watchdog #(
        .ALU_TIMEOUT(ALU_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_comb begin
        nxt   = st;
        a_n   = a_q;
        b_n   = b_q;
        sub_n = sub_q;
        res_n = res_q;
        ovf_n = ovf_q;
        if (k_clr) begin
            nxt   = S_IDLE;
            a_n   = '0;
            b_n   = '0;
            sub_n = 1'b0;
            res_n = '0;
            ovf_n = 1'b0;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (k_ent) begin
                        a_n = operand;
                        nxt = S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (k_op) begin
                        sub_n = k_sub;
                        nxt   = S_GOT_OP;
                    end else if (k_ent) begin
                        a_n = operand;
                    end
                end
                S_GOT_OP: begin
                    if (k_ent) begin
                        b_n = operand;
                        nxt = S_GOT_B;
                    end else if (k_op) begin
                        sub_n = k_sub;
                    end
                end
                S_GOT_B: begin
                    if (k_eq) begin
                        nxt = S_EXEC;
                    end else if (k_ent) begin
                        b_n = operand;
                    end
                end
                S_EXEC: begin
                    nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (alu.alu_done) begin
                        res_n = alu.alu_result;
                        ovf_n = alu.alu_ovf;
                        nxt   = S_SHOW;
                    end else if (wd_expired) begin
                        nxt = S_ERR;
                    end
                end
                S_SHOW: begin
                    if (k_op) begin
                        a_n   = res_q;
                        sub_n = k_sub;
                        nxt   = S_GOT_OP;
                    end else if (k_ent) begin
                        a_n = operand;
                        nxt = S_GOT_A;
                    end else if (k_eq) begin
                        a_n = res_q;
                        nxt = S_EXEC;
                    end
                end
                S_ERR: begin
                    nxt = S_ERR;
                end
                default: begin
                    nxt = S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are decoded from the next state so they are
    // registered yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st      <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st      <= nxt;
            a_q     <= a_n;
            b_q     <= b_n;
            sub_q   <= sub_n;
            res_q   <= res_n;
            ovf_q   <= ovf_n;
            start_q <= (nxt == S_EXEC);
            busy_q  <= (nxt == S_EXEC) || (nxt == S_WAIT);
            err_q   <= (nxt == S_ERR);
        end
    end

    assign alu.alu_start = start_q;
    assign alu.alu_a     = a_q;
    assign alu.alu_b     = b_q;
    assign alu.alu_sub   = sub_q;
    assign result        = res_q;
    assign overflow      = ovf_q;
    assign busy          = busy_q;
    assign error         = err_q;
    assign state         = st;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed keypad/ALU scenarios,
// a cycle-level reference model of the calculator and literal spot checks.
module tb_calc_sequencer;

    localparam int TO = 15;

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;
    localparam logic [3:0] K_ENT = 4'hE;
    localparam logic [3:0] K_EQ  = 4'hF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] operand = 8'h00;
    logic [7:0] result;
    logic       overflow;
    logic       busy;
    logic       error;
    logic [2:0] state;

    calc_if alu_bus ();

    initial begin
        alu_bus.alu_done   = 1'b0;
        alu_bus.alu_result = 8'h00;
        alu_bus.alu_ovf    = 1'b0;
    end

    always #5 clk = ~clk;

    calc_sequencer #(
        .ALU_TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .operand  (operand),
        .alu      (alu_bus.master),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .error    (error),
        .state    (state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the calculator as seen from the keypad and display.
    int         m_st;
    logic [7:0] m_a, m_b, m_res;
    logic       m_sub, m_ovf;
    int         m_idle_waits;
    bit         m_valid = 1'b0;

    task automatic m_clear();
        m_st = 0;
        m_a = 8'h00;
        m_b = 8'h00;
        m_res = 8'h00;
        m_sub = 1'b0;
        m_ovf = 1'b0;
        m_idle_waits = 0;
    endtask

    always @(posedge clk) begin
        bit is_op;
        is_op = key_valid && (key_code == K_ADD || key_code == K_SUB);
        if (!reset) begin
            m_clear();
            m_valid = 1'b1;
        end else if (key_valid && key_code == K_CLR) begin
            m_clear();
        end else if (m_st == 0) begin
            if (key_valid && key_code == K_ENT) begin
                m_a = operand;
                m_st = 1;
            end
        end else if (m_st == 1) begin
            if (is_op) begin
                m_sub = (key_code == K_SUB);
                m_st = 2;
            end else if (key_valid && key_code == K_ENT) begin
                m_a = operand;
            end
        end else if (m_st == 2) begin
            if (key_valid && key_code == K_ENT) begin
                m_b = operand;
                m_st = 3;
            end else if (is_op) begin
                m_sub = (key_code == K_SUB);
            end
        end else if (m_st == 3) begin
            if (key_valid && key_code == K_EQ) m_st = 4;
            else if (key_valid && key_code == K_ENT) m_b = operand;
        end else if (m_st == 4) begin
            m_idle_waits = 0;
            m_st = 5;
        end else if (m_st == 5) begin
            if (alu_bus.alu_done) begin
                m_res = alu_bus.alu_result;
                m_ovf = alu_bus.alu_ovf;
                m_st = 6;
            end else begin
                m_idle_waits++;
                if (m_idle_waits >= TO) m_st = 7;
            end
        end else if (m_st == 6) begin
            if (is_op) begin
                m_a = m_res;
                m_sub = (key_code == K_SUB);
                m_st = 2;
            end else if (key_valid && key_code == K_ENT) begin
                m_a = operand;
                m_st = 1;
            end else if (key_valid && key_code == K_EQ) begin
                m_a = m_res;
                m_st = 4;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", {5'b0, state}, 8'(m_st));
            chk("busy", {7'b0, busy}, {7'b0, (m_st == 4 || m_st == 5)});
            chk("error", {7'b0, error}, {7'b0, (m_st == 7)});
            chk("alu_start", {7'b0, alu_bus.alu_start}, {7'b0, (m_st == 4)});
            chk("alu_a", alu_bus.alu_a, m_a);
            chk("alu_b", alu_bus.alu_b, m_b);
            chk("alu_sub", {7'b0, alu_bus.alu_sub}, {7'b0, m_sub});
            chk("result", result, m_res);
            chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] code, input logic [7:0] opnd);
        key_valid = 1'b1;
        key_code  = code;
        operand   = opnd;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // Called in the EXEC cycle; answers after `dly` idle WAIT cycles.
    task automatic alu_reply(input logic [7:0] res, input logic ovf,
                             input int dly);
        tick();
        repeat (dly) tick();
        alu_bus.alu_done   = 1'b1;
        alu_bus.alu_result = res;
        alu_bus.alu_ovf    = ovf;
        tick();
        alu_bus.alu_done   = 1'b0;
        alu_bus.alu_result = 8'h00;
        alu_bus.alu_ovf    = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_state", {5'b0, state}, 8'h00);
        chk("rst_result", result, 8'h00);

        // 5 + 3
        key(K_ENT, 8'h05);
        key(K_ADD, 8'h00);
        key(K_ENT, 8'h03);
        key(K_EQ, 8'h00);
        chk("add_start", {7'b0, alu_bus.alu_start}, 8'h01);
        chk("add_a", alu_bus.alu_a, 8'h05);
        chk("add_b", alu_bus.alu_b, 8'h03);
        alu_reply(8'h08, 1'b0, 0);
        chk("add_state", {5'b0, state}, 8'h06);
        chk("add_result", result, 8'h08);
        chk("add_ovf", {7'b0, overflow}, 8'h00);
        chk("add_start_off", {7'b0, alu_bus.alu_start}, 8'h00);

        // 10 - 15, with a done during EXEC that must be ignored
        key(K_ENT, 8'h0A);
        key(K_SUB, 8'h00);
        key(K_ENT, 8'h0F);
        key(K_EQ, 8'h00);
        chk("sub_op", {7'b0, alu_bus.alu_sub}, 8'h01);
        alu_bus.alu_done   = 1'b1;
        alu_bus.alu_result = 8'h55;
        tick();
        alu_bus.alu_done   = 1'b0;
        chk("exec_done_ignored", {5'b0, state}, 8'h05);
        alu_bus.alu_done   = 1'b1;
        alu_bus.alu_result = 8'hFB;
        tick();
        alu_bus.alu_done   = 1'b0;
        alu_bus.alu_result = 8'h00;
        chk("sub_result", result, 8'hFB);

        // chain: (-5) + 5
        key(K_ADD, 8'h00);
        chk("chain_state", {5'b0, state}, 8'h02);
        chk("chain_a", alu_bus.alu_a, 8'hFB);
        key(K_ENT, 8'h05);
        key(K_EQ, 8'h00);
        chk("chain_sub", {7'b0, alu_bus.alu_sub}, 8'h00);
        alu_reply(8'h00, 1'b0, 2);
        chk("chain_result", result, 8'h00);

        // repeat with EQUALS: 0 + 5
        key(K_EQ, 8'h00);
        chk("rep_a", alu_bus.alu_a, 8'h00);
        chk("rep_b", alu_bus.alu_b, 8'h05);
        alu_reply(8'h05, 1'b0, 0);
        chk("rep_result", result, 8'h05);

        // overflow passthrough
        key(K_CLR, 8'h00);
        key(K_ENT, 8'h7F);
        key(K_ADD, 8'h00);
        key(K_ENT, 8'h01);
        key(K_EQ, 8'h00);
        alu_reply(8'h80, 1'b1, 1);
        chk("ovf_result", result, 8'h80);
        chk("ovf_flag", {7'b0, overflow}, 8'h01);

        // watchdog timeout
        key(K_CLR, 8'h00);
        key(K_ENT, 8'h01);
        key(K_ADD, 8'h00);
        key(K_ENT, 8'h02);
        key(K_EQ, 8'h00);
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("to_wait", {5'b0, state}, 8'h05);
            tick();
        end
        chk("to_state", {5'b0, state}, 8'h07);
        chk("to_error", {7'b0, error}, 8'h01);
        key(K_ENT, 8'h33);
        key(K_ADD, 8'h00);
        key(K_EQ, 8'h00);
        alu_bus.alu_done = 1'b1;
        tick();
        alu_bus.alu_done = 1'b0;
        chk("err_sticky", {5'b0, state}, 8'h07);
        key(K_CLR, 8'h00);
        chk("clr_state", {5'b0, state}, 8'h00);
        chk("clr_error", {7'b0, error}, 8'h00);
        chk("clr_a", alu_bus.alu_a, 8'h00);

        // abort: CLEAR together with done, then a late done
        key(K_ENT, 8'h03);
        key(K_ADD, 8'h00);
        key(K_ENT, 8'h04);
        key(K_EQ, 8'h00);
        tick();
        alu_bus.alu_done   = 1'b1;
        alu_bus.alu_result = 8'h07;
        key(K_CLR, 8'h00);
        tick();
        alu_bus.alu_done   = 1'b0;
        alu_bus.alu_result = 8'h00;
        chk("abort_state", {5'b0, state}, 8'h00);
        chk("abort_result", result, 8'h00);

        // reset mid-WAIT, coincident with CLEAR
        key(K_ENT, 8'h01);
        key(K_SUB, 8'h00);
        key(K_ENT, 8'h02);
        key(K_EQ, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        key(K_CLR, 8'h00);
        reset = 1'b1;
        chk("rst_wait_state", {5'b0, state}, 8'h00);
        chk("rst_wait_busy", {7'b0, busy}, 8'h00);
        chk("rst_wait_sub", {7'b0, alu_bus.alu_sub}, 8'h00);

        // operator keys in GOT_B are ignored
        key(K_ENT, 8'h09);
        key(K_ADD, 8'h00);
        key(K_ENT, 8'h02);
        key(K_SUB, 8'h00);
        key(K_ADD, 8'h00);
        chk("gotb_state", {5'b0, state}, 8'h03);
        chk("gotb_sub", {7'b0, alu_bus.alu_sub}, 8'h00);
        key(K_EQ, 8'h00);
        alu_reply(8'h0B, 1'b0, 0);
        chk("gotb_result", result, 8'h0B);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
